rr_burst_arbiter: RTL and testbench
===================================

// Module: rr_burst_arbiter
// PURPOSE
//  Round-robin arbiter that shares one burst-oriented resource between N requesters.
//  Sequences each ownership window as a registered grant; requesters drive the data-path checkers (a/b/c/d).
//  The window closes on the owner's last beat, owner withdrawal or a hold timeout.
//  A mandatory dead cycle separates consecutive owners.
//  Sits in front of the shared checker datapath; grant qualifies which requester's stream is sampled.
// PARAMETERS
//  N         4   number of requesters (2..16)
//  MAX_HOLD  8   max consecutive grant cycles per window (2..255)
//  IDW       $clog2(N)  width of gnt_id (derived, not overridden)
// PORTS
//  clk          in   1    single clock, all logic on posedge clk
//  rst          in   1    asynchronous, active-high reset
//  req          in   N    per-requester request, level, held until granted or withdrawn
//  last         in   1    owner's final beat; valid only while busy
//  gnt          out  N    one-hot grant, registered; all-zero when idle
//  gnt_id       out  IDW  index of current owner; 0 when no grant
//  busy         out  1    high while any gnt bit is high
//  timeout_err  out  1    one-cycle pulse when a window is force-closed by MAX_HOLD
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0,
//   rr_ptr=0, hold_cnt=0.
//  States: IDLE, GRANT, RELEASE.
//  IDLE: if |req, pick first i in rr_ptr, rr_ptr+1, ... (mod N) with req[i]=1;
//   next edge gnt=1<<i, gnt_id=i, hold_cnt=1, go GRANT. Req-to-gnt latency = 1 clk.
//  GRANT (evaluated each edge, priority order):
//   1) last=1            -> normal close.
//   2) req[gnt_id]=0     -> abort close, no error.
//   3) hold_cnt==MAX_HOLD -> forced close; timeout_err=1 for that next cycle only.
//   4) else              -> hold_cnt+1, stay.
//   On any close: next edge gnt=0, busy=0, gnt_id=0, go RELEASE.
//   rr_ptr=(owner+1) mod N, wrap N-1 -> 0.
//  last and timeout in same cycle: last wins, no timeout_err.
//  RELEASE: exactly one dead cycle, gnt=0, then IDLE.
//   Back-to-back owners: last at edge t -> gnt low t+1..t+2 -> next gnt at t+3.
//  Requests of non-owners during GRANT/RELEASE are ignored until IDLE; no queuing.
//  last outside GRANT is ignored.
//  hold_cnt saturates at MAX_HOLD (width $clog2(MAX_HOLD+1)); never wraps.
//  gnt is always one-hot or zero.
//  busy == |gnt, gnt[gnt_id] == busy.
//  rst asserted mid-window: gnt drops asynchronously, no timeout_err, rr_ptr returns to 0.
// TESTING
//  T1 reset: rst=1 with req=4'hF -> gnt=0, busy=0, timeout_err=0 throughout.
//   rst release -> gnt=4'b0001 one clk later.
//  T2 rotation: req=4'hF held, last pulsed 2 clks after each grant ->
//   grant order 0,1,2,3,0, each gnt separated by 2 idle clks.
//  T3 timeout: req[2]=1 only, never last ->
//   gnt[2] high exactly 8 clks, timeout_err one pulse; regrant to 2 after dead cycle.
//  T4 abort: gnt[1] active, drop req[1] at clk 3 ->
//   gnt=0 next clk, no timeout_err, next grant goes to requester 2 if requesting.
//  T5 collision: last=1 on same cycle hold_cnt==8 -> normal close, timeout_err stays 0.
//  T6 reset mid-window: rst pulse while gnt=4'b1000 ->
//   gnt=0 immediately; after release req=4'hF grants requester 0.
//  SVA: one-hot gnt; gnt |-> req[gnt_id]$past or closing; close |=> !busy ##1 !busy;
//   busy |-> hold_cnt<=MAX_HOLD.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//
// Round-robin arbiter sharing one burst-oriented resource between N requesters.
// Each ownership window is a registered one-hot grant.  A window closes on the
// owner's last beat, on owner withdrawal, or when the hold limit is reached.
// Exactly one dead cycle separates consecutive owners, so with last sampled at
// edge t the grant is low for t+1..t+2 and the next owner appears at t+3.
//
// Parameters
//   N         number of requesters (2..16)
//   MAX_HOLD  maximum consecutive grant cycles per window (2..255)
//   IDW       width of gnt_id, derived as $clog2(N)
//
// Ports
//   clk          in   1    clock, all logic on posedge
//   rst          in   1    asynchronous active-high reset
//   req          in   N    level requests, held until granted or withdrawn
//   last         in   1    owner's final beat, only looked at while granting
//   gnt          out  N    registered one-hot grant, zero when idle
//   gnt_id       out  IDW  index of current owner, zero when no grant
//   busy         out  1    high while any grant bit is high
//   timeout_err  out  1    one-cycle pulse when a window is force-closed
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           last,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           timeout_err
);

   localparam int HCW = $clog2(MAX_HOLD + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);
   localparam logic [N-1:0]   GNT_ONE  = {{(N-1){1'b0}}, 1'b1};

   logic [1:0]     state_q,  state_d;
   logic [N-1:0]   gnt_q,    gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [HCW-1:0] hold_q,   hold_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic           tmo_q,    tmo_d;

   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   logic           owner_req;
   logic           hold_at_max;
   logic           close_evt;

   // Hold counter never wraps: it sticks at MAX_HOLD.
   function automatic logic [HCW-1:0] hold_sat_inc(input logic [HCW-1:0] v);
      if (v >= HOLD_MAX) begin
         return HOLD_MAX;
      end
      return v + HCW'(1);
   endfunction

   // Pointer to the requester after the departing owner, wrapping N-1 -> 0
   // explicitly so non-power-of-two N works.
   function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] owner);
      if (owner == ID_LAST) begin
         return '0;
      end
      return owner + IDW'(1);
   endfunction

   // Search rr_ptr, rr_ptr+1, ... (mod N) for the first active request.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'(idx);
         end
      end
   end

   assign owner_req   = req[gnt_id_q];
   assign hold_at_max = (hold_q == HOLD_MAX);
   assign close_evt   = (state_q == S_GRANT) && (last || !owner_req || hold_at_max);

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      hold_d   = hold_q;
      rr_ptr_d = rr_ptr_q;
      tmo_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               gnt_d    = GNT_ONE << pick_idx;
               gnt_id_d = pick_idx;
               hold_d   = HCW'(1);
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            if (close_evt) begin
               // last has priority over the hold limit, and a withdrawn
               // request is a quiet abort, so the error flags only the
               // genuinely stuck window.
               tmo_d    = !last && owner_req && hold_at_max;
               gnt_d    = '0;
               gnt_id_d = '0;
               hold_d   = '0;
               rr_ptr_d = ptr_after(gnt_id_q);
               state_d  = S_RELEASE;
            end else begin
               hold_d = hold_sat_inc(hold_q);
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         hold_q   <= '0;
         rr_ptr_q <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         hold_q   <= hold_d;
         rr_ptr_q <= rr_ptr_d;
         tmo_q    <= tmo_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_id      = gnt_id_q;
   assign busy        = |gnt_q;
   assign timeout_err = tmo_q;

   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_q));

   a_busy_matches_id: assert property (@(posedge clk) disable iff (rst)
      busy == gnt_q[gnt_id_q]);

   a_idle_id_zero: assert property (@(posedge clk) disable iff (rst)
      !busy |-> (gnt_id_q == '0));

   a_owner_requested: assert property (@(posedge clk) disable iff (rst)
      busy |-> |($past(req) & gnt_q));

   a_dead_cycles: assert property (@(posedge clk) disable iff (rst)
      close_evt |=> !busy ##1 !busy);

   a_hold_bound: assert property (@(posedge clk) disable iff (rst)
      busy |-> (hold_q <= HOLD_MAX));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_burst_arbiter
//
// Drives rr_burst_arbiter with directed scenarios followed by random requests,
// last beats and resets.  A window-level reference model (current owner, cycles
// owned, dead-cycle countdown, next search start) predicts every output.
// -----------------------------------------------------------------------------
module tb_rr_burst_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int IDW      = $clog2(N);

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic           last;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           timeout_err;

   always #5 clk = ~clk;

   rr_burst_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .last        (last),
      .gnt         (gnt),
      .gnt_id      (gnt_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner = -1 when nobody holds the resource.
   int m_owner;
   int m_held;
   int m_cool;
   int m_next;
   bit m_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_cool  = 0;
      m_next  = 0;
      m_to    = 1'b0;
   endtask

   // One clock edge of the arbitration rules, using the inputs seen at it.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            if (last || !req[m_owner] || m_held == MAX_HOLD) begin
               m_to    = !last && req[m_owner] && (m_held == MAX_HOLD);
               m_next  = (m_owner + 1) % N;
               m_owner = -1;
               m_held  = 0;
               m_cool  = 1;
            end else begin
               m_held++;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
               if (m_owner < 0 && req[(m_next + k) % N]) begin
                  m_owner = (m_next + k) % N;
               end
            end
            m_held = 1;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      logic [N-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk({tag, ".gnt"},    32'(gnt),         32'(eg));
      chk({tag, ".gnt_id"}, 32'(gnt_id),      (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk({tag, ".busy"},   32'(busy),        32'(m_owner >= 0));
      chk({tag, ".tmo"},    32'(timeout_err), 32'(m_to));
   endtask

   // Advance one clock; inputs are stable from the previous falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
   endtask

   initial begin
      int hi_cnt;
      int to_cnt;

      // T1: reset held with every requester asking.
      req  = 4'hF;
      last = 1'b0;
      rst  = 1'b1;
      model_reset();
      #1;
      compare_all("t1_async");
      @(negedge clk);
      repeat (3) step("t1_rst");
      rst = 1'b0;
      step("t1_rel");
      chk("t1_first_gnt", 32'(gnt), 32'h1);

      // T2: rotation 0,1,2,3,0 with last two clocks after each grant.
      for (int g = 0; g < 5; g++) begin
         chk("t2_order", 32'(gnt_id), 32'(g % N));
         step("t2_own");
         last = 1'b1;
         step("t2_close");
         last = 1'b0;
         chk("t2_gap1", 32'(gnt), 32'h0);
         step("t2_dead");
         chk("t2_gap2", 32'(gnt), 32'h0);
         if (g == 4) req = '0;
         step("t2_next");
      end
      repeat (3) step("t2_drain");

      // T3: lone requester that never signals last.
      req    = 4'b0100;
      hi_cnt = 0;
      to_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step("t3");
         if (gnt[2]) hi_cnt++;
         if (timeout_err) to_cnt++;
      end
      chk("t3_hold_cycles", 32'(hi_cnt), 32'd8);
      chk("t3_to_pulses", 32'(to_cnt), 32'd1);
      step("t3_regrant");
      chk("t3_regrant_id", 32'(gnt_id), 32'd2);
      chk("t3_regrant_busy", 32'(busy), 32'd1);
      req = '0;
      repeat (3) step("t3_drain");

      // T4: owner 1 withdraws on its third grant cycle.
      req = 4'b0010;
      step("t4_grant");
      chk("t4_owner", 32'(gnt), 32'h2);
      req = 4'b0110;
      step("t4_own2");
      step("t4_own3");
      req = 4'b0100;
      step("t4_abort");
      chk("t4_abort_gnt", 32'(gnt), 32'h0);
      chk("t4_abort_tmo", 32'(timeout_err), 32'd0);
      step("t4_dead");
      step("t4_next");
      chk("t4_next_id", 32'(gnt_id), 32'd2);

      // T5: last arrives on the same edge the hold limit is hit.
      repeat (MAX_HOLD - 1) step("t5_own");
      last = 1'b1;
      step("t5_close");
      last = 1'b0;
      chk("t5_no_tmo", 32'(timeout_err), 32'd0);
      chk("t5_closed", 32'(busy), 32'd0);
      req = '0;
      repeat (3) step("t5_drain");

      // T6: asynchronous reset in the middle of requester 3's window.
      req = 4'b1000;
      step("t6_grant");
      chk("t6_owner", 32'(gnt), 32'h8);
      step("t6_own");
      rst = 1'b1;
      model_reset();
      #1;
      chk("t6_async_drop", 32'(gnt), 32'h0);
      compare_all("t6_async");
      @(negedge clk);
      step("t6_rst");
      rst = 1'b0;
      req = 4'hF;
      step("t6_rel");
      chk("t6_after_rst", 32'(gnt), 32'h1);

      // Random traffic: sticky requests, sparse last, rare resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         last = ($urandom_range(0, 9) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         if (rst) begin
            model_reset();
            #1;
            compare_all("rnd_async");
         end
         step("rnd");
      end
      rst  = 1'b0;
      req  = '0;
      last = 1'b0;
      repeat (4) step("end");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
